// File: rtl/fmad_pkg.sv
// fmad_pkg: shared constants and state encoding for the fmad job sequencer
package fmad_pkg;
   localparam logic [31:0] CMD_FMA32 = 32'd1;
   localparam logic [31:0] CMD_DOT16 = 32'd13;
   localparam int FMAD_LAT = 2;
   typedef enum logic [1:0] {IDLE, CLR, RUN, DRAIN} state_t;
endpackage

// File: rtl/fmad_res_fifo.sv
// fmad_res_fifo: synchronous result FIFO with free-entry count
module fmad_res_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 37
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   free
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   assign valid = wp != rp;
   assign dout = valid ? mem[rp[AW-1:0]] : '0;
   assign free = (AW+1)'(DEPTH) - (wp - rp);
   // storage array, written on push; a full FIFO may push while it pops
   always_ff @(posedge clk)
      if (push) mem[wp[AW-1:0]] <= din;
   // read/write pointers with an extra wrap bit to tell full from empty
   always_ff @(posedge clk)
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
      end
endmodule

// File: rtl/fmad_seq.sv
// fmad_seq: job sequencer driving operand beats and commands into fmad
module fmad_seq
   import fmad_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LENW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_op,
   input  logic [LENW-1:0] cmd_len,
   input  logic            cmd_clr,
   input  logic            opd_valid,
   output logic            opd_ready,
   input  logic [31:0]     opd_x,
   input  logic [31:0]     opd_y,
   input  logic [31:0]     opd_z,
   input  logic [31:0]     opd_w,
   output logic [31:0]     fmad_x,
   output logic [31:0]     fmad_y,
   output logic [31:0]     fmad_z,
   output logic [31:0]     fmad_w,
   output logic            fmad_req,
   output logic [31:0]     fmad_cmd,
   output logic            fmad_reset,
   input  logic [31:0]     fmad_rslt,
   input  logic [4:0]      fmad_flag,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [31:0]     res_data,
   output logic [4:0]      res_flag,
   output logic            dot_done,
   output logic            busy
);
   localparam int AW = $clog2(DEPTH);
   state_t state, state_nx;
   logic job_op, job_clr, drn, accept, last_beat;
   logic [LENW-1:0] cnt;
   logic [FMAD_LAT-1:0] inf_v, inf_f;
   logic [AW:0] free, fma_inf;
   assign cmd_ready = !reset && state == IDLE && (inf_v == '0 || (cmd_op == job_op && !cmd_clr));
   assign accept = cmd_valid & cmd_ready;
   assign opd_ready = state == RUN && (job_op || free > fma_inf);
   assign fmad_req = opd_valid & opd_ready;
   assign last_beat = fmad_req && cnt == '0;
   assign fmad_cmd = job_op ? CMD_DOT16 : CMD_FMA32;
   assign fmad_reset = reset | (state == CLR & job_clr);
   assign {fmad_x, fmad_y, fmad_z, fmad_w} = {opd_x, opd_y, opd_z, opd_w};
   assign dot_done = state == DRAIN && drn;
   assign busy = state != IDLE || inf_v != '0;
   // FMA32 beats still in the fmad pipeline, each needing a FIFO slot later
   always_comb begin
      fma_inf = '0;
      for (int i = 0; i < FMAD_LAT; i++) fma_inf = fma_inf + (AW+1)'(inf_f[i]);
   end
   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (cmd_op & cmd_clr) ? CLR : RUN;
         CLR:     state_nx = RUN;
         RUN:     if (last_beat) state_nx = job_op ? DRAIN : IDLE;
         DRAIN:   if (drn) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_nx;
   // job registers, beat counter, in-flight tracking and drain phase
   always_ff @(posedge clk)
      if (reset) begin
         job_op <= 1'b0;
         job_clr <= 1'b0;
         cnt <= '0;
         inf_v <= '0;
         inf_f <= '0;
         drn <= 1'b0;
      end else begin
         if (accept) begin
            job_op <= cmd_op;
            job_clr <= cmd_op & cmd_clr;
            cnt <= cmd_len;
         end else if (fmad_req) cnt <= cnt - 1'b1;
         inf_v <= {inf_v[FMAD_LAT-2:0], fmad_req};
         inf_f <= {inf_f[FMAD_LAT-2:0], fmad_req & ~job_op};
         drn <= state == DRAIN && !drn;
      end
   fmad_res_fifo #(.DEPTH(DEPTH), .W(37)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (inf_f[FMAD_LAT-1]),
      .pop   (res_valid & res_ready),
      .din   ({fmad_flag, fmad_rslt}),
      .dout  ({res_flag, res_data}),
      .valid (res_valid),
      .free  (free)
   );
endmodule

// File: doc/fmad_seq.md
# fmad_seq

Job sequencer for the `fmad` datapath. It accepts job descriptors: either a stream of FP32 fused multiply-adds or a BF16 dot-product burst. It drives the operand beats into `fmad` with the correct `req`/`req_command`, and keeps `req_command` stable while any operation is in flight. It clears the BF16 accumulators on request and buffers FP32 results in a small FIFO with backpressure. It sits between the operand fetch engine and `fmad`.

## Interface
- `DEPTH`, 4: FP32 result FIFO entries (power of 2, ≥ 2).
- `LENW`, 8: width of `cmd_len`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: job descriptor handshake.
- `cmd_op` in 1: job type; 0 = FMA32, 1 = DOT16.
- `cmd_len` in LENW: beat count minus 1.
- `cmd_clr` in 1: DOT16 only; clear the accumulators before the first beat.
- `opd_valid` in 1 / `opd_ready` out 1: operand beat handshake.
- `opd_x`, `opd_y`, `opd_z`, `opd_w` in 32 each: operands, forwarded combinationally to `fmad` x/y/z/w.
- `fmad_req` out 1: equals `opd_valid & opd_ready`.
- `fmad_cmd` out 32: 1 (FMA32) or 13 (DOT16).
- `fmad_reset` out 1: `reset | clr_pulse`.
- `fmad_rslt` in 32, `fmad_flag` in 5: `fmad` FP32 outputs.
- `res_valid` out 1 / `res_ready` in 1: FP32 result stream.
- `res_data` out 32, `res_flag` out 5: FP32 result and its flags.
- `dot_done` out 1: one-cycle pulse when the DOT16 accumulators (`acc*`/`exp*` on `fmad`) are final.
- `busy` out 1: state ≠ IDLE or any operation in flight.

## Operation
- States and transitions:
  - IDLE → CLR when a DOT16 job with `cmd_clr` is accepted.
  - IDLE → RUN when any other job is accepted.
  - CLR → RUN after exactly 1 cycle.
  - RUN → DRAIN on the last DOT16 beat.
  - RUN → IDLE on the last FMA32 beat.
  - DRAIN → IDLE after 2 cycles; `dot_done` is asserted in the second DRAIN cycle.
- `cmd_ready` is asserted only in IDLE, and only if the in-flight shift register `inf[1:0]` is zero or the new job has the same op as the last job with `cmd_clr` = 0.
  - Switching op, or clearing, therefore waits for the pipeline to empty.
- Job registers latch `op`, `len`, and `clr` on acceptance. The beat counter loads `cmd_len` and decrements on each issue; the last beat is the one issued when the counter reads 0.
- `fmad_cmd` comes from the job `op` register. It holds its value from acceptance through the end of DRAIN and while `inf` ≠ 0.
- `opd_ready` in RUN:
  - DOT16: always 1.
  - FMA32: 1 only if FIFO free entries > number of FMA32 beats in `inf`.
  - Outside RUN: 0.
- `inf` shifts in `fmad_req` every cycle, with a tag bit recording whether the beat was FMA32.
- The FIFO captures `{fmad_flag, fmad_rslt}` at the end of the cycle in which `inf[1]` holds an FMA32 beat. Capture never overflows, by construction of `opd_ready`.
- `clr_pulse` is asserted during CLR only. `inf` is 0 at that point, so no in-flight beat is lost.
- `reset`: state → IDLE, FIFO and `inf` flushed, beat counter → 0.
- Simultaneous FIFO push and pop is allowed, including when the FIFO is full (pop frees a slot in the same cycle).

## Timing
- Reset values: `cmd_ready` 0 during reset, 1 in the first IDLE cycle after it. `opd_ready`, `fmad_req`, `res_valid`, `dot_done`, and `busy` are 0. `fmad_cmd` is 1. `fmad_reset` is 1 during reset. `res_data` and `res_flag` are 0.
- An FMA32 beat issued in cycle t is captured at the end of t+2; `res_valid` can be high at the earliest in t+3.
- Full throughput of 1 beat/cycle is sustained while `res_ready` stays high.
- For a DOT16 last beat in cycle t, the accumulator is final from cycle t+2, and `dot_done` pulses in t+2.
- Accepting a command costs 1 cycle (IDLE); the first beat can issue the cycle after acceptance, or 2 cycles after if the job passes through CLR.
- An op switch adds at most 2 idle cycles.

## Structure
- `fmad_pkg` holds:
  - `CMD_FMA32` = 1, `CMD_DOT16` = 13;
  - `FMAD_LAT` = 2;
  - the state enum `{IDLE, CLR, RUN, DRAIN}`.
- Sub-module `fmad_res_fifo`: synchronous FIFO, DEPTH × 37 bits, with a free-count output.
- The FSM, beat counter, and `inf` live in `fmad_seq`.

## Test plan
- FMA32 job with `len` = 3, `res_ready` = 1: 4 beats issue in consecutive cycles and 4 results arrive starting in cycle t+3. Operands x=0x3f800000, y=0x40000000, z=0x3f800000 give `res_data` 0x40400000 and `res_flag` 0.
- FMA32 job with `len` = 15, `res_ready` = 0: `opd_ready` drops after 4 issues. Raising `res_ready` resumes issue, and all 16 results emerge in order with none lost.
- DOT16 job with `clr` = 1, `len` = 1, following an FMA32 job: `cmd_ready` stays low until `inf` = 0, `fmad_reset` pulses once, the beats issue with `fmad_cmd` = 13, and `dot_done` pulses 2 cycles after the last beat.
- Two back-to-back DOT16 jobs with the second having `clr` = 0: the second is accepted without an extra wait cycle, and the accumulators are not cleared between the jobs.
- `reset` asserted mid-RUN with 2 beats in flight: the next cycle shows IDLE, `res_valid` = 0, and `busy` = 0, and no stale result is emitted afterwards.
